hvac_zone_scheduler: RTL
========================

# hvac_zone_scheduler

Shares one heat pump between `NZONES` zone thermostat controllers, each of which raises a heat or cool request. The block picks the pump mode (heat or cool) by majority vote and opens zone dampers for the zones being served. It enforces anti-short-cycle timing: a minimum on-time, a minimum off-time and a forced changeover after a maximum run. It sits between the per-zone controllers and the pump/damper drivers.

## Interface
- `NZONES`, 4: number of zones, 2..16.
- `MIN_ON`, 8: minimum consecutive cycles a mode output stays high.
- `MIN_OFF`, 4: cycles both mode outputs are held low after any run.
- `MAX_RUN`, 32: run length after which a pending opposite request forces an exit. Must be ≥ `MIN_ON`.
- `CNT_W`, 8: run/off timer width. Must hold `MAX_RUN`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `heat_req` in `NZONES`: per-zone heat request.
- `cool_req` in `NZONES`: per-zone cool request.
- `heat_on` out 1: pump in heating mode.
- `cool_on` out 1: pump in cooling mode.
- `damper` out `NZONES`: zone damper open mask.
- `conflict` out `NZONES`: zone asserting both requests.
- `changeovers` out 16: run count. Present only with `HVAC_SCHED_STATS_EN`.

## Operation
- Valid requests:
  - `vh = heat_req & ~cool_req`
  - `vc = cool_req & ~heat_req`
  - `hc` = popcount(`vh`), `cc` = popcount(`vc`).
- A zone with both requests is ignored for voting and damper selection.
- States: IDLE, HEAT, COOL, OFF. A timer `tmr` clears on every state entry and increments, saturating, each cycle in HEAT/COOL/OFF. `last_mode` records the mode of the most recent run.
- **IDLE:**
  - `hc`=`cc`=0: stay.
  - `hc`>`cc`: go to HEAT.
  - `cc`>`hc`: go to COOL.
  - Tie with nonzero counts: go to the mode opposite `last_mode`.
- **HEAT:**
  - Exit is allowed only when `tmr` ≥ `MIN_ON`-1.
  - Go to OFF if exit is allowed and either `hc`=0, or `cc`>0 and `tmr` ≥ `MAX_RUN`-1.
  - Otherwise stay. `last_mode` is set to HEAT on entry.
- **COOL:** symmetric to HEAT, with `hc` and `cc` swapped.
- **OFF:** go to IDLE when `tmr` = `MIN_OFF`-1.
- A zone's request dropping during a run only closes that zone's damper. The mode persists until the exit rule fires.

## Timing
- All outputs are registered.
  - `heat_on` = (state==HEAT).
  - `cool_on` = (state==COOL).
  - `damper` is `vh` in HEAT, `vc` in COOL, and 0 otherwise, sampled one cycle earlier.
  - `conflict` is `heat_req & cool_req`, one cycle latency.
- Request seen in IDLE at edge k: mode output high from edge k+1.
- Damper latency: in cycle k+1, `damper` reflects the requests sampled at edge k; thereafter it tracks requests with one cycle latency.
- Each run keeps its mode output high for ≥ `MIN_ON` and ≤ `MAX_RUN` cycles when opposite requests are pending. With no opposing demand, a run is unbounded.
- After any run: exactly `MIN_OFF` cycles in OFF, then 1 cycle in IDLE. The next mode output rises at the earliest `MIN_OFF`+1 cycles after the previous one fell.
- `heat_on` and `cool_on` are never high together, and never both change without an OFF gap.
- Reset (any time, including mid-run), effective at the next edge:
  - state=IDLE, `tmr`=0, `last_mode`=COOL, so the first tie goes to HEAT.
  - `heat_on`=`cool_on`=0, `damper`=0, `conflict`=0, `changeovers`=0.
- Reset mid-run does not impose `MIN_OFF`. The pump driver owns power-up lockout.

## Configuration
- `HVAC_SCHED_STATS_EN` defined:
  - Adds the `changeovers` port.
  - Incremented on every entry into HEAT or COOL.
  - Saturates at 16'hFFFF; cleared by reset.
- `HVAC_SCHED_STATS_EN` undefined: no port, no counter logic. All other behaviour is identical.

## Test plan
Defaults for all scenarios: `NZONES`=4, `MIN_ON`=8, `MIN_OFF`=4, `MAX_RUN`=32.
- **Minimum on/off:** `heat_req`=0001 for 2 cycles, then 0 → `heat_on` high for exactly 8 cycles. `damper`=0001 for 1 cycle, then 0000. Both mode outputs low for 4 OFF cycles plus 1 IDLE cycle.
- **Tie and forced changeover:** `heat_req`=0011 and `cool_req`=1100, held → HEAT first with `damper`=0011. `heat_on` drops after 32 cycles, then 4 OFF cycles and 1 IDLE cycle, then `cool_on`=1 with `damper`=1100. The sequence alternates every 37 cycles.
- **Majority:** `heat_req`=0001, `cool_req`=1110 from IDLE → `cool_on`=1 next cycle, `damper`=1110, `heat_on` stays 0.
- **Conflict:** `heat_req`=`cool_req`=0001 → `conflict`=0001 one cycle later. No mode entered; `damper`=0.
- **Reset mid-run:** assert `reset` on the 3rd cycle of HEAT → next cycle all outputs 0 and state IDLE. Requests still held → HEAT re-entered 2 cycles after reset release.
- **Stats (`HVAC_SCHED_STATS_EN` defined):** run the tie scenario for 3 runs → `changeovers`=3. Preload near saturation → holds 16'hFFFF.

Source files
------------

// File: rtl/hvac_zone_scheduler.sv
// Heat-pump mode scheduler: majority vote across zones, anti-short-cycle timing, damper control.
// Optional run counter port `changeovers` is built when HVAC_SCHED_STATS_EN is defined.
module hvac_zone_scheduler #(
    parameter int NZONES  = 4,
    parameter int MIN_ON  = 8,
    parameter int MIN_OFF = 4,
    parameter int MAX_RUN = 32,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NZONES-1:0] heat_req,
    input  logic [NZONES-1:0] cool_req,
    output logic              heat_on,
    output logic              cool_on,
    output logic [NZONES-1:0] damper,
    output logic [NZONES-1:0] conflict
`ifdef HVAC_SCHED_STATS_EN
    ,
    output logic [15:0]       changeovers
`endif
);

    localparam int CW = $clog2(NZONES + 1);

    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_RUN - 1);
    localparam logic [CNT_W-1:0] TMR_SAT   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAT = 2'd1,
        S_COOL = 2'd2,
        S_OFF  = 2'd3
    } state_t;

    function automatic logic [CW-1:0] popcount(input logic [NZONES-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < NZONES; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  tmr_q;
    logic              last_heat_q;

    logic [NZONES-1:0] vh;
    logic [NZONES-1:0] vc;
    logic [CW-1:0]     hc;
    logic [CW-1:0]     cc;
    logic              exit_ok;
    logic              run_max;
    logic              entering;

    // Zones asserting both requests are dropped from voting and damper selection.
    assign vh = heat_req & ~cool_req;
    assign vc = cool_req & ~heat_req;
    assign hc = popcount(vh);
    assign cc = popcount(vc);

    assign exit_ok  = (tmr_q >= ON_LAST);
    assign run_max  = (tmr_q >= RUN_LAST);
    assign entering = (state_d != state_q);

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (hc > cc) begin
                    state_d = S_HEAT;
                end else if (cc > hc) begin
                    state_d = S_COOL;
                end else if (hc != '0) begin
                    // Tie with live demand alternates relative to the previous run.
                    state_d = last_heat_q ? S_COOL : S_HEAT;
                end
            end
            S_HEAT: begin
                if (exit_ok && ((hc == '0) || ((cc != '0) && run_max))) begin
                    state_d = S_OFF;
                end
            end
            S_COOL: begin
                if (exit_ok && ((cc == '0) || ((hc != '0) && run_max))) begin
                    state_d = S_OFF;
                end
            end
            S_OFF: begin
                if (tmr_q == OFF_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            last_heat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (entering) begin
                tmr_q <= '0;
            end else if ((state_q != S_IDLE) && (tmr_q != TMR_SAT)) begin
                tmr_q <= tmr_q + 1'b1;
            end
            if (entering && (state_d == S_HEAT)) begin
                last_heat_q <= 1'b1;
            end else if (entering && (state_d == S_COOL)) begin
                last_heat_q <= 1'b0;
            end
        end
    end

    // Outputs are registered from the current state, one cycle behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            heat_on  <= 1'b0;
            cool_on  <= 1'b0;
            damper   <= '0;
            conflict <= '0;
        end else begin
            heat_on  <= (state_q == S_HEAT);
            cool_on  <= (state_q == S_COOL);
            conflict <= heat_req & cool_req;
            case (state_q)
                S_HEAT:  damper <= vh;
                S_COOL:  damper <= vc;
                default: damper <= '0;
            endcase
        end
    end

`ifdef HVAC_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            changeovers <= '0;
        end else if (entering && ((state_d == S_HEAT) || (state_d == S_COOL))
                     && (changeovers != 16'hFFFF)) begin
            changeovers <= changeovers + 16'd1;
        end
    end
`endif

endmodule
